demorgan_checker: RTL and testbench
===================================

// Module: demorgan_checker
// PURPOSE
//  Sequential self-test engine for the 2-input De Morgan gate block.
//  - Sweeps every {A,B} input combination over one or more passes and drives dut_a/dut_b.
//  - Waits a programmable settle time, then samples the block's 8 outputs and compares them against golden values.
//  - Counts mismatches and reports done/pass.
//  - Sits beside the gate block in the lab/bring-up top level, as the stimulus-and-check end of its interface.
// PARAMETERS
//  SETTLE_CYCLES  1  idle cycles between driving a vector and sampling dut_out (0 allowed)
//  NUM_PASSES     1  full 4-vector sweeps per run (>=1)
//  ERR_W          8  width of saturating mismatch counter
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  start      in   1      run request, sampled only in IDLE/DONE
//  dut_a      out  1      drive to gate block input A
//  dut_b      out  1      drive to gate block input B
//  dut_out    in   8      {nAorB,nAandB,nAornB,nAandnB,AorB,AandB,nB,nA}; bit0=nA
//  busy       out  1      run in progress
//  done       out  1      run finished; held until next start
//  pass       out  1      valid when done: err_count==0
//  err_count  out  ERR_W  mismatching vectors this run, saturates at all-ones
// BEHAVIOUR
//  - Reset (async, any state): FSM=IDLE; all outputs 0; vector and pass counters 0.
//  - Vector index v={A,B} (A is MSB), swept 0,1,2,3 per pass.
//  - Golden dut_out by v: 0:0xF3  1:0x69  2:0x6A  3:0x0C.
//  - FSM states: IDLE, DRIVE, SETTLE, CHECK, DONE.
//    IDLE/DONE + start -> DRIVE; clear err_count, pass, done, vector and pass counters.
//    DRIVE: register dut_a/dut_b from v -> SETTLE (or straight to CHECK if SETTLE_CYCLES==0).
//    SETTLE: count SETTLE_CYCLES cycles -> CHECK.
//    CHECK: compare sampled dut_out (all 8 bits) against golden; any differing bit = one mismatch.
//      On mismatch, err_count += 1, saturating.
//      Then, if last vector of last pass -> DONE, else advance v (wrap 3->0, bump pass) -> DRIVE.
//    DONE: done=1, pass=(err_count==0), busy=0; dut_a/dut_b return to 0.
//  - Per-vector cost SETTLE_CYCLES+2 cycles.
//  - done rises 4*NUM_PASSES*(SETTLE_CYCLES+2)+1 edges after the edge that sampled start.
//  - busy=1 in DRIVE/SETTLE/CHECK only.
//  - start while busy is ignored (no restart, no count change).
//  - start in DONE starts a fresh run; done drops the next cycle.
//  - Reset mid-run aborts immediately; no partial result is retained.
//  - dut_out is sampled only in CHECK; changes in other cycles have no effect.
// CONFIGURATION
//  DEMORGAN_CHK_CAPTURE_EN defined: adds three output ports, all reset to 0 and cleared on start.
//    fail_valid (1): set on the first mismatch of a run.
//    fail_vec   (2): v of that mismatch.
//    fail_obs   (8): dut_out of that mismatch.
//    Fields hold their values until the next start or reset.
//  DEMORGAN_CHK_CAPTURE_EN undefined: the three ports and their registers do not exist.
//    Counting, done and pass behaviour is unchanged.
// STRUCTURE
//  Shared package demorgan_pkg:
//    FSM state encoding.
//    Output bit-index constants (IDX_NA=0 .. IDX_NAORB=7).
//    4-entry golden table constant GOLDEN[v].
//  One sub-module, demorgan_golden: combinational v -> expected 8-bit word, from the package table.
//    Reused later by other bench blocks.
//  Top holds the FSM, settle/vector/pass counters, the error counter and the optional capture.
// TESTING
//  1. Ideal gate model, NUM_PASSES=1, SETTLE_CYCLES=1; pulse start.
//     -> busy 1 next cycle; done at edge 13; pass=1; err_count=0.
//  2. Model with nAorB (bit7) stuck-at-0, NUM_PASSES=3.
//     -> only v=0 fails; err_count=3; pass=0.
//     -> capture on: fail_vec=0, fail_obs=0x73.
//  3. ERR_W=2, model outputs inverted, NUM_PASSES=2.
//     -> 8 mismatches; err_count saturates at 3; pass=0.
//  4. Start re-pulsed during SETTLE of v=2.
//     -> ignored; done time and err_count same as test 1.
//  5. Reset asserted mid-CHECK with err_count=1.
//     -> same cycle: busy=0, dut_a=dut_b=0, err_count=0.
//     -> after release, stays IDLE until start.
//  6. From DONE with err_count=2, pulse start with ideal model.
//     -> done drops; new run ends pass=1, err_count=0, fail_valid=0.

Source files
------------

// File: rtl/demorgan_pkg.sv
// Shared definitions for the De Morgan gate-block self-test: FSM encoding, output bit
// positions and the golden response table indexed by v = {A,B}.
package demorgan_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRIVE  = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_CHECK  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

    localparam int unsigned IDX_NA      = 0;
    localparam int unsigned IDX_NB      = 1;
    localparam int unsigned IDX_AANDB   = 2;
    localparam int unsigned IDX_AORB    = 3;
    localparam int unsigned IDX_NAANDNB = 4;
    localparam int unsigned IDX_NAORNB  = 5;
    localparam int unsigned IDX_NAANDB  = 6;
    localparam int unsigned IDX_NAORB   = 7;

    localparam int unsigned NUM_VECS = 4;

    // Entry 0 sits in the low byte, so GOLDEN[v] is the expected word for vector v.
    localparam logic [3:0][7:0] GOLDEN = {8'h0C, 8'h6A, 8'h69, 8'hF3};

    function automatic logic [7:0] golden_word(input logic [1:0] v);
        return GOLDEN[v];
    endfunction

endpackage

// File: rtl/demorgan_golden.sv
// Combinational golden-response lookup: vector index {A,B} to expected 8-bit gate-block output.
module demorgan_golden
    import demorgan_pkg::*;
(
    input  logic [1:0] vec,
    output logic [7:0] expected
);

    assign expected = golden_word(vec);

endmodule

// File: rtl/demorgan_checker.sv
// Sequential self-test engine for the 2-input De Morgan gate block.
// Optional first-failure capture ports are enabled by defining DEMORGAN_CHK_CAPTURE_EN.
module demorgan_checker
    import demorgan_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned NUM_PASSES    = 1,
    parameter int unsigned ERR_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             dut_a,
    output logic             dut_b,
    input  logic [7:0]       dut_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count
`ifdef DEMORGAN_CHK_CAPTURE_EN
    ,
    output logic             fail_valid,
    output logic [1:0]       fail_vec,
    output logic [7:0]       fail_obs
`endif
);

    localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int unsigned PW = (NUM_PASSES > 1) ? $clog2(NUM_PASSES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);
    localparam logic [PW-1:0] PASS_LAST   = PW'((NUM_PASSES == 0) ? 0 : NUM_PASSES - 1);

    logic [2:0]    state;
    logic [1:0]    vec;
    logic [PW-1:0] pass_cnt;
    logic [SW-1:0] settle_cnt;
    logic [7:0]    expected;
    logic          mismatch;
    logic          last_vec;

    demorgan_golden u_golden (
        .vec      (vec),
        .expected (expected)
    );

    assign mismatch = (dut_out != expected);
    assign last_vec = (vec == 2'd3) && (pass_cnt == PASS_LAST);
    assign busy     = (state == ST_DRIVE) || (state == ST_SETTLE) || (state == ST_CHECK);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            dut_a      <= 1'b0;
            dut_b      <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            vec        <= '0;
            pass_cnt   <= '0;
            settle_cnt <= '0;
`ifdef DEMORGAN_CHK_CAPTURE_EN
            fail_valid <= 1'b0;
            fail_vec   <= '0;
            fail_obs   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_DRIVE;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        err_count <= '0;
                        vec       <= '0;
                        pass_cnt  <= '0;
`ifdef DEMORGAN_CHK_CAPTURE_EN
                        fail_valid <= 1'b0;
                        fail_vec   <= '0;
                        fail_obs   <= '0;
`endif
                    end else if (state == ST_DONE) begin
                        // Result flags become visible one cycle after entering DONE.
                        done <= 1'b1;
                        pass <= (err_count == '0);
                    end
                end
                ST_DRIVE: begin
                    dut_a      <= vec[1];
                    dut_b      <= vec[0];
                    settle_cnt <= '0;
                    state      <= (SETTLE_CYCLES == 0) ? ST_CHECK : ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        state <= ST_CHECK;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_CHECK: begin
                    if (mismatch) begin
                        if (err_count != '1) begin
                            err_count <= err_count + 1'b1;
                        end
`ifdef DEMORGAN_CHK_CAPTURE_EN
                        if (!fail_valid) begin
                            fail_valid <= 1'b1;
                            fail_vec   <= vec;
                            fail_obs   <= dut_out;
                        end
`endif
                    end
                    if (last_vec) begin
                        state <= ST_DONE;
                        dut_a <= 1'b0;
                        dut_b <= 1'b0;
                    end else begin
                        vec   <= vec + 1'b1;
                        state <= ST_DRIVE;
                        if (vec == 2'd3) begin
                            pass_cnt <= pass_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_demorgan_checker.sv
// Self-checking bench for demorgan_checker: directed table, hand-written corner sequences
// and randomized fault masks against a boolean-level reference model.
module tb_demorgan_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start0, start1;
    logic       a0, b0, a1, b1;
    logic [7:0] out0, out1;
    logic       busy0, busy1, done0, done1, pass0, pass1;
    logic [7:0] err0;
    logic [1:0] err1;
    logic [31:0] mask0, mask1;
`ifdef DEMORGAN_CHK_CAPTURE_EN
    logic       fv0, fv1;
    logic [1:0] fvec0, fvec1;
    logic [7:0] fobs0, fobs1;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    int sel = 0;
    int edge_cnt = 0;

    always #5 clk = ~clk;

    demorgan_checker #(.SETTLE_CYCLES(1), .NUM_PASSES(1), .ERR_W(8)) u_dut0 (
        .clk(clk), .reset(reset), .start(start0), .dut_a(a0), .dut_b(b0), .dut_out(out0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
`ifdef DEMORGAN_CHK_CAPTURE_EN
        , .fail_valid(fv0), .fail_vec(fvec0), .fail_obs(fobs0)
`endif
    );

    demorgan_checker #(.SETTLE_CYCLES(0), .NUM_PASSES(3), .ERR_W(2)) u_dut1 (
        .clk(clk), .reset(reset), .start(start1), .dut_a(a1), .dut_b(b1), .dut_out(out1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef DEMORGAN_CHK_CAPTURE_EN
        , .fail_valid(fv1), .fail_vec(fvec1), .fail_obs(fobs1)
`endif
    );

    // Behavioural gate block: De Morgan outputs from their boolean definitions.
    function automatic logic [7:0] ideal(input logic a, input logic b);
        return {~(a | b), ~(a & b), ~a | ~b, ~a & ~b, a | b, a & b, ~b, ~a};
    endfunction

    function automatic logic [7:0] pick(input logic [31:0] m, input int v);
        return m[8*v +: 8];
    endfunction

    always_comb begin
        out0 = ideal(a0, b0) ^ pick(mask0, int'({a0, b0}));
        out1 = ideal(a1, b1) ^ pick(mask1, int'({a1, b1}));
    end

    logic       cur_busy, cur_done, cur_pass, cur_a, cur_b;
    logic [7:0] cur_err;
    always_comb begin
        cur_busy = (sel == 0) ? busy0 : busy1;
        cur_done = (sel == 0) ? done0 : done1;
        cur_pass = (sel == 0) ? pass0 : pass1;
        cur_a    = (sel == 0) ? a0 : a1;
        cur_b    = (sel == 0) ? b0 : b1;
        cur_err  = (sel == 0) ? err0 : {6'b0, err1};
    end
`ifdef DEMORGAN_CHK_CAPTURE_EN
    logic       cur_fv;
    logic [1:0] cur_fvec;
    logic [7:0] cur_fobs;
    always_comb begin
        cur_fv   = (sel == 0) ? fv0 : fv1;
        cur_fvec = (sel == 0) ? fvec0 : fvec1;
        cur_fobs = (sel == 0) ? fobs0 : fobs1;
    end
`endif

    typedef struct {
        int          inst;
        logic [31:0] mask;
        int          exp_err;
        logic        exp_pass;
        int          exp_edges;
        logic        exp_fv;
        int          exp_fvec;
        logic [7:0]  exp_fobs;
    } vec_t;

    // Reference model: every nonzero mask byte is one mismatching vector per pass.
    function automatic int model_err(input int inst, input logic [31:0] m);
        int n = 0;
        int passes = (inst == 0) ? 1 : 3;
        int sat = (inst == 0) ? 255 : 3;
        for (int v = 0; v < 4; v++) if (pick(m, v) != 0) n++;
        n = n * passes;
        return (n > sat) ? sat : n;
    endfunction

    function automatic int model_edges(input int inst);
        int settle = (inst == 0) ? 1 : 0;
        int passes = (inst == 0) ? 1 : 3;
        return 4 * passes * (settle + 2) + 1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        edge_cnt++;
    endtask

    task automatic start_run(input int inst);
        @(negedge clk);
        sel = inst;
        if (inst == 0) start0 = 1'b1; else start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        edge_cnt = 0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (!cur_done && k < 300) begin
            step();
            k++;
        end
        chk("done_seen", {31'b0, cur_done}, 32'd1);
    endtask

    task automatic run_vec(input vec_t t, input string tag);
        if (t.inst == 0) mask0 = t.mask; else mask1 = t.mask;
        start_run(t.inst);
        chk({tag, "_busy_after_start"}, {31'b0, cur_busy}, 32'd1);
        wait_done();
        chk({tag, "_done_edge"}, edge_cnt, t.exp_edges);
        chk({tag, "_err_count"}, {24'b0, cur_err}, t.exp_err);
        chk({tag, "_pass"}, {31'b0, cur_pass}, {31'b0, t.exp_pass});
        chk({tag, "_idle_outputs"}, {29'b0, cur_busy, cur_a, cur_b}, 32'd0);
`ifdef DEMORGAN_CHK_CAPTURE_EN
        chk({tag, "_fail_valid"}, {31'b0, cur_fv}, {31'b0, t.exp_fv});
        chk({tag, "_fail_vec"}, {30'b0, cur_fvec}, t.exp_fvec);
        chk({tag, "_fail_obs"}, {24'b0, cur_fobs}, {24'b0, t.exp_fobs});
`endif
    endtask

    vec_t table_v [7];

    initial begin
        vec_t r;
        int   k;
        table_v[0] = '{0, 32'h0000_0000, 0, 1'b1, 13, 1'b0, 0, 8'h00};
        table_v[1] = '{1, 32'h0000_0080, 3, 1'b0, 25, 1'b1, 0, 8'h73};
        table_v[2] = '{1, 32'hFFFF_FFFF, 3, 1'b0, 25, 1'b1, 0, 8'h0C};
        table_v[3] = '{0, 32'h0100_0000, 1, 1'b0, 13, 1'b1, 3, 8'h0D};
        table_v[4] = '{0, 32'h0002_1000, 2, 1'b0, 13, 1'b1, 1, 8'h79};
        table_v[5] = '{1, 32'h0004_0000, 3, 1'b0, 25, 1'b1, 2, 8'h6E};
        table_v[6] = '{0, 32'hFFFF_FFFF, 4, 1'b0, 13, 1'b1, 0, 8'h0C};

        reset = 1'b1; start0 = 1'b0; start1 = 1'b0; mask0 = '0; mask1 = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs0", {busy0, done0, pass0, a0, b0, err0}, 0);
        chk("reset_outputs1", {busy1, done1, pass1, a1, b1, err1}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) run_vec(table_v[i], $sformatf("row%0d", i));

        // Start re-pulsed during SETTLE of v=2 must be ignored.
        mask0 = '0;
        start_run(0);
        k = 0;
        while (!(cur_a && !cur_b) && k < 50) begin step(); k++; end
        chk("restart_v2_reached", {30'b0, cur_a, cur_b}, 32'd2);
        start0 = 1'b1;
        step();
        start0 = 1'b0;
        wait_done();
        chk("restart_done_edge", edge_cnt, 13);
        chk("restart_err_count", {24'b0, cur_err}, 0);
        chk("restart_pass", {31'b0, cur_pass}, 1);

        // Reset mid-CHECK of v=1 with one error already counted.
        mask0 = 32'h0000_00FF;
        start_run(0);
        repeat (5) step();
        chk("midrst_pre_err", {24'b0, err0}, 1);
        chk("midrst_pre_ab", {30'b0, a0, b0}, 1);
        reset = 1'b1;
        #1;
        chk("midrst_async", {busy0, a0, b0, err0}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("midrst_stays_idle", {29'b0, busy0, done0, pass0}, 0);

        // Fresh run from DONE with err_count=2.
        run_vec(table_v[4], "pre_rerun");
        mask0 = '0;
        start_run(0);
        chk("rerun_done_drops", {31'b0, done0}, 0);
        wait_done();
        chk("rerun_err", {24'b0, err0}, 0);
        chk("rerun_pass", {31'b0, pass0}, 1);
`ifdef DEMORGAN_CHK_CAPTURE_EN
        chk("rerun_fail_valid", {31'b0, fv0}, 0);
`endif

        for (int i = 0; i < 24; i++) begin
            r.inst = int'($urandom_range(0, 1));
            r.mask = '0;
            r.exp_fv = 1'b0;
            r.exp_fvec = 0;
            r.exp_fobs = 8'h00;
            for (int v = 0; v < 4; v++) begin
                if ($urandom_range(0, 1) == 1) r.mask[8*v +: 8] = 8'($urandom_range(1, 255));
            end
            for (int v = 3; v >= 0; v--) begin
                if (pick(r.mask, v) != 0) begin
                    r.exp_fv = 1'b1;
                    r.exp_fvec = v;
                    r.exp_fobs = ideal(v[1], v[0]) ^ pick(r.mask, v);
                end
            end
            r.exp_err = model_err(r.inst, r.mask);
            r.exp_pass = (r.exp_err == 0);
            r.exp_edges = model_edges(r.inst);
            run_vec(r, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
